// File: rtl/score_digit_feeder_pkg.sv
// Shared widths and FSM encoding for the score digit feeder and its BCD adjust slice.
// NUM_W matches the num input width of the singleNumber glyph renderers.
package score_digit_feeder_pkg;

  localparam int BCD_W = 4;
  localparam int SR_W  = 20;
  localparam int NUM_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/score_digit_feeder_bcd_adjust.sv
// One double-dabble correction slice: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module score_digit_feeder_bcd_adjust
  import score_digit_feeder_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_W'(5)) ? i_digit + BCD_W'(3) : i_digit;

endmodule

// File: rtl/score_digit_feeder.sv
// Converts an 8-bit score to three BCD digits with a sequential double-dabble engine and
// presents them to the glyph renderers, updating the shown digits only on the frame tick.
module score_digit_feeder
  import score_digit_feeder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_load,
  input  logic             i_frame_tick,
  output logic             o_busy,
  output logic [NUM_W-1:0] o_num2,
  output logic [NUM_W-1:0] o_num1,
  output logic [NUM_W-1:0] o_num0,
  output logic             o_blank2,
  output logic             o_blank1,
  output logic             o_digits_valid
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int PEND_W = DIGITS * BCD_W;

  state_t              state, state_next;
  logic [SR_W-1:0]     sr, sr_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                busy, busy_next;
  logic                done_now;
  logic [PEND_W-1:0]   adj_bcd;
  logic [PEND_W-1:0]   pending;
  logic                pend_valid;
  logic [PEND_W-1:0]   display;
  logic                blank2, blank1, digits_valid;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    score_digit_feeder_bcd_adjust u_adj (
      .i_digit (sr[WIDTH + d*BCD_W +: BCD_W]),
      .o_digit (adj_bcd[d*BCD_W +: BCD_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      cnt   <= cnt_next;
      busy  <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    busy_next  = busy;
    done_now   = 1'b0;
    case (state)
      IDLE: begin
        if (i_load) begin
          sr_next    = SR_W'(i_value);
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sr_next  = SR_W'({adj_bcd, sr[WIDTH-1:0]} << 1);
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
        busy_next  = 1'b0;
        done_now   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The tick consumes the pending bank as it was before this edge; a result completing
  // on the same edge re-arms pend_valid afterwards and waits for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      pend_valid   <= 1'b0;
      display      <= '0;
      blank2       <= 1'b0;
      blank1       <= 1'b0;
      digits_valid <= 1'b0;
    end else begin
      if (i_frame_tick && pend_valid) begin
        display      <= pending;
        pend_valid   <= 1'b0;
        digits_valid <= 1'b1;
        blank2       <= (BLANK_LZ != 0) && (pending[PEND_W-1 -: BCD_W] == '0);
        blank1       <= (BLANK_LZ != 0) && (pending[PEND_W-1 -: BCD_W] == '0)
                        && (pending[PEND_W-BCD_W-1 -: BCD_W] == '0);
      end
      if (done_now) begin
        pending    <= sr[SR_W-1:WIDTH];
        pend_valid <= 1'b1;
      end
    end
  end

  assign o_busy         = busy;
  assign o_num2         = NUM_W'(display[PEND_W-1 -: BCD_W]);
  assign o_num1         = NUM_W'(display[PEND_W-BCD_W-1 -: BCD_W]);
  assign o_num0         = NUM_W'(display[BCD_W-1:0]);
  assign o_blank2       = blank2;
  assign o_blank1       = blank1;
  assign o_digits_valid = digits_valid;

endmodule
